// File: rtl/ahb2apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// ahb2apb_bridge_pkg
// Shared definitions for the AHB-Lite to APB3 bridge.
//   - HTRANS_* : AHB transfer type codes
//   - HRESP_*  : AHB response codes
//   - bridge_state_e : 3-bit bridge FSM state encoding
//   - is_xfer_req()  : AHB address-phase acceptance test
// -----------------------------------------------------------------------------
package ahb2apb_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } bridge_state_e;

    // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY never start a transfer.
    function automatic logic is_xfer_req(input logic       sel,
                                         input logic [1:0] trans,
                                         input logic       ready);
        return sel & trans[1] & ready;
    endfunction

endpackage

// File: rtl/ahb2apb_bridge_apb_pready_timeout.sv
// -----------------------------------------------------------------------------
// apb_pready_timeout
// Counts APB ACCESS cycles spent waiting on pready and flags the last
// permitted wait cycle so the bridge can force an error response.
// Ports:
//   clk      in   bridge clock
//   rst_n    in   synchronous active-low reset
//   i_clr    in   clear the count (held while the bridge is in SETUP)
//   i_en     in   count one waited cycle (ACCESS with pready low)
//   o_expire out  this waited cycle is the last one allowed
// PREADY_TO = 0 disables the timeout entirely (o_expire never asserts).
// -----------------------------------------------------------------------------
module apb_pready_timeout #(
    parameter int PREADY_TO = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = (PREADY_TO > 0) ? $clog2(PREADY_TO + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = (PREADY_TO > 0) ? CNT_W'(PREADY_TO - 1) : '0;
    localparam logic TO_ENABLED = (PREADY_TO > 0) ? 1'b1 : 1'b0;

    logic [CNT_W-1:0] r_cnt;

    // Wait-cycle counter; with the timeout disabled it may wrap harmlessly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = TO_ENABLED & i_en & (r_cnt == LAST_CNT);

endmodule

// File: rtl/ahb2apb_bridge.sv
// -----------------------------------------------------------------------------
// ahb2apb_bridge
// AHB-Lite slave to APB3 master bridge. Each accepted AHB single transfer is
// issued as one APB SETUP + ACCESS sequence. pslverr, or pready staying low for
// PREADY_TO ACCESS cycles, becomes a two-cycle AHB ERROR response.
// All AHB and APB outputs come straight from registers.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   hsel, haddr, htrans, hwrite,
//   hsize, hwdata, hready              AHB-Lite slave inputs (hsize ignored)
//   hreadyout, hresp, hrdata           AHB-Lite slave outputs
//   psel, penable, pwrite, paddr,
//   pwdata                             APB3 master outputs
//   prdata, pready, pslverr            APB3 master inputs
// -----------------------------------------------------------------------------
module ahb2apb_bridge
    import ahb2apb_bridge_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PREADY_TO = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    bridge_state_e     r_state;
    logic              r_hreadyout;
    logic              r_hresp;
    logic [DATA_W-1:0] r_hrdata;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;

    logic w_accept;
    logic w_to_clr;
    logic w_to_en;
    logic w_to_expire;
    logic w_unused_hsize;

    // All transfers go out as full-width APB accesses, so the size is not used.
    assign w_unused_hsize = ^hsize;

    assign w_accept = is_xfer_req(hsel, htrans, hready);
    assign w_to_clr = (r_state == ST_SETUP);
    assign w_to_en  = (r_state == ST_ACCESS) & ~pready;

    apb_pready_timeout #(
        .PREADY_TO (PREADY_TO)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_to_clr),
        .i_en     (w_to_en),
        .o_expire (w_to_expire)
    );

    // Bridge FSM; every output is loaded on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_hrdata    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            case (r_state)
                // ERR2 behaves like IDLE for acceptance; its hresp=1 was loaded on entry.
                ST_IDLE, ST_ERR2: begin
                    r_hresp   <= HRESP_OKAY;
                    r_penable <= 1'b0;
                    if (w_accept) begin
                        r_paddr     <= haddr;
                        r_pwrite    <= hwrite;
                        r_hreadyout <= 1'b0;
                        if (hwrite) begin
                            // Write data only arrives in the next (data-phase) cycle.
                            r_state <= ST_WDATA;
                            r_psel  <= 1'b0;
                        end else begin
                            r_state <= ST_SETUP;
                            r_psel  <= 1'b1;
                        end
                    end else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_psel      <= 1'b0;
                    end
                end
                ST_WDATA: begin
                    r_pwdata <= hwdata;
                    r_psel   <= 1'b1;
                    r_state  <= ST_SETUP;
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (pslverr) begin
                            r_hresp <= HRESP_ERROR;
                            r_state <= ST_ERR1;
                        end else begin
                            r_hreadyout <= 1'b1;
                            r_state     <= ST_IDLE;
                            if (!r_pwrite) begin
                                r_hrdata <= prdata;
                            end else begin
                                r_hrdata <= r_hrdata;
                            end
                        end
                    end else if (w_to_expire) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_hresp   <= HRESP_ERROR;
                        r_state   <= ST_ERR1;
                    end else begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ERR1: begin
                    // Second error cycle: hresp stays high while hreadyout rises.
                    r_hresp     <= HRESP_ERROR;
                    r_hreadyout <= 1'b1;
                    r_state     <= ST_ERR2;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                end
            endcase
        end
    end

    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;
    assign hrdata    = r_hrdata;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;

endmodule
